pp_wr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one pp_wr_fifo write port among N_REQ requester channels.

---
 rtl/pp_arb_pkg.sv | 31 +++
 rtl/pp_rr_pick.sv | 34 +++
 rtl/pp_wr_arbiter.sv | 123 ++++++++++++
 tb/tb_pp_wr_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pp_arb_pkg.sv
// Shared definitions for the pp_wr_arbiter slice.
//  - arb_state_e : arbiter FSM state encoding
//  - clog2       : ceil(log2(value)), never less than 1, usable in constant expressions
//  - DEF_*       : default parameter values
package pp_arb_pkg;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    localparam int unsigned DEF_N_REQ     = 4;
    localparam int unsigned DEF_WIDTH     = 48;
    localparam int unsigned DEF_MAX_BURST = 16;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        int unsigned p;
        r = 0;
        p = 1;
        while (p < value) begin
            p = p * 2;
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pp_rr_pick.sv
// Combinational round-robin picker.
//  req        in   N_REQ   request vector
//  last_grant in   GID_W   index granted last; it gets the lowest priority
//  pick       out  GID_W   first requesting index after last_grant (wrapping)
//  any_valid  out  1       at least one request present
module pp_rr_pick
    import pp_arb_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    localparam int unsigned GID_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [GID_W-1:0] last_grant,
    output logic [GID_W-1:0] pick,
    output logic             any_valid
);

    int unsigned idx;

    // Scan last_grant+1 .. last_grant+N_REQ, so last_grant itself is checked last.
    always_comb begin
        pick      = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = (32'(last_grant) + k) % N_REQ;
            if (!any_valid && req[idx[GID_W-1:0]]) begin
                any_valid = 1'b1;
                pick      = idx[GID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pp_wr_arbiter.sv
// Round-robin arbiter sharing one pp_wr_fifo write port among N_REQ requesters.
// A grant lasts for one burst, ended by req_last or capped at MAX_BURST words.
// Writes are gated by fifo_f_full, so no word is ever lost.
//  clk, rst      clock; synchronous active-high reset
//  req_valid     per-requester word valid
//  req_data      requester i data at [i*WIDTH +: WIDTH]
//  req_last      last word of requester burst (qualified by valid)
//  req_ready     word accepted when valid & ready at the same edge
//  fifo_wr_en    FIFO write enable
//  fifo_wr_data  FIFO write data (zero when not writing)
//  fifo_f_full   FIFO full flag
//  grant_id      current / most recent owner
//  busy          high while a burst is granted
//  burst_trunc   one-cycle pulse after a burst is released by the MAX_BURST cap
module pp_wr_arbiter
    import pp_arb_pkg::*;
#(
    parameter int unsigned N_REQ     = DEF_N_REQ,
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned MAX_BURST = DEF_MAX_BURST,
    localparam int unsigned GID_W    = clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]       req_last,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   fifo_wr_en,
    output logic [WIDTH-1:0]       fifo_wr_data,
    input  logic                   fifo_f_full,
    output logic [GID_W-1:0]       grant_id,
    output logic                   busy,
    output logic                   burst_trunc
);

    localparam int unsigned BCNT_W = clog2(MAX_BURST + 1);
    localparam logic [BCNT_W-1:0] BEAT_CAP = BCNT_W'(MAX_BURST - 1);
    localparam logic [GID_W-1:0]  GID_RST  = GID_W'(N_REQ - 1);

    arb_state_e        state_q, state_d;
    logic [GID_W-1:0]  grant_q, grant_d;
    logic [BCNT_W-1:0] beat_q, beat_d;
    logic              trunc_q, trunc_d;

    logic [GID_W-1:0]  pick;
    logic              any_valid;
    int unsigned       owner;

    pp_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req        (req_valid),
        .last_grant (grant_q),
        .pick       (pick),
        .any_valid  (any_valid)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        beat_d       = beat_q;
        trunc_d      = 1'b0;
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        owner        = 32'(grant_q);

        case (state_q)
            ST_ARB: begin
                if (any_valid) begin
                    grant_d = pick;
                    beat_d  = '0;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                req_ready[grant_q] = !fifo_f_full;
                fifo_wr_en         = req_valid[grant_q] && !fifo_f_full;
                if (fifo_wr_en) begin
                    fifo_wr_data = req_data[owner*WIDTH +: WIDTH];
                    beat_d       = beat_q + 1'b1;
                    // req_last wins over the cap when both land on the same beat.
                    if (req_last[grant_q]) begin
                        state_d = ST_ARB;
                    end else if (beat_q == BEAT_CAP) begin
                        state_d = ST_ARB;
                        trunc_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase

        // Handshake is killed combinationally while reset is asserted.
        if (rst) begin
            req_ready    = '0;
            fifo_wr_en   = 1'b0;
            fifo_wr_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ARB;
            grant_q <= GID_RST;
            beat_q  <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            beat_q  <= beat_d;
            trunc_q <= trunc_d;
        end
    end

    assign grant_id    = grant_q;
    assign busy        = (state_q == ST_BURST);
    assign burst_trunc = trunc_q;

endmodule

// File: tb/tb_pp_wr_arbiter.sv
// Self-checking bench for pp_wr_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level reference model.
module tb_pp_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 48;
    localparam int MB = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic             fifo_wr_en;
    logic [W-1:0]     fifo_wr_data;
    logic             fifo_f_full;
    logic [1:0]       grant_id;
    logic             busy;
    logic             burst_trunc;

    always #5 clk = ~clk;

    pp_wr_arbiter #(
        .N_REQ     (N),
        .WIDTH     (W),
        .MAX_BURST (MB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_f_full  (fifo_f_full),
        .grant_id     (grant_id),
        .busy         (busy),
        .burst_trunc  (burst_trunc)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pending words per requester: {last, data}
    logic [W:0] q [N][$];

    // Stimulus knobs
    logic         rst_drv = 1'b1;
    logic         full_drv = 1'b0;
    logic [N-1:0] vmask = '1;
    int           gap_pct = 0;
    int           full_pct = 0;
    int           phase_wr = 0;
    int           trunc_seen = 0;
    int           seq = 0;
    int           wr_gid [$];

    // Reference model: owner (-1 when arbitrating), last grant, beats in burst, pending trunc pulse
    int m_owner = -1;
    int m_gid   = N - 1;
    int m_cnt   = 0;
    bit m_trunc = 1'b0;

    task automatic load_burst(input int r, input int len);
        for (int k = 0; k < len; k++) begin
            logic [W-1:0] d;
            d = {8'(r), 8'(k), 32'(seq)};
            seq++;
            q[r].push_back({(k == len - 1), d});
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) begin
            if (q[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic cycle();
        logic [N-1:0] exp_ready;
        logic         exp_wr;
        logic [W-1:0] exp_data;
        @(negedge clk);
        rst         = rst_drv;
        fifo_f_full = full_drv | ($urandom_range(99) < full_pct);
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0 && vmask[i] && $urandom_range(99) >= gap_pct) begin
                req_valid[i]        = 1'b1;
                req_data[i*W +: W]  = q[i][0][W-1:0];
                req_last[i]         = q[i][0][W];
            end else begin
                req_valid[i]        = 1'b0;
                req_data[i*W +: W]  = W'({$urandom(), $urandom()});
                req_last[i]         = 1'($urandom_range(1));
            end
        end
        #1;
        exp_ready = '0;
        exp_wr    = 1'b0;
        exp_data  = '0;
        if (!rst_drv && m_owner >= 0) begin
            exp_ready[m_owner] = !fifo_f_full;
            exp_wr = req_valid[m_owner] && !fifo_f_full;
            if (exp_wr) exp_data = req_data[m_owner*W +: W];
        end
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("wr_en", 64'(fifo_wr_en), 64'(exp_wr));
        check("wr_data", 64'(fifo_wr_data), 64'(exp_data));
        check("busy", 64'(busy), 64'(m_owner >= 0));
        check("grant_id", 64'(grant_id), 64'(m_gid));
        check("burst_trunc", 64'(burst_trunc), 64'(m_trunc));

        if (fifo_wr_en) begin
            phase_wr++;
            wr_gid.push_back(int'(grant_id));
        end
        if (burst_trunc) trunc_seen++;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) void'(q[i].pop_front());
        end

        if (rst_drv) begin
            m_owner = -1;
            m_gid   = N - 1;
            m_cnt   = 0;
            m_trunc = 1'b0;
        end else if (m_owner < 0) begin
            m_trunc = 1'b0;
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (m_gid + k) % N;
                if (m_owner < 0 && req_valid[idx]) begin
                    m_owner = idx;
                    m_gid   = idx;
                    m_cnt   = 0;
                end
            end
        end else begin
            m_trunc = 1'b0;
            if (exp_wr) begin
                m_cnt++;
                if (req_last[m_owner]) begin
                    m_owner = -1;
                end else if (m_cnt == MB) begin
                    m_owner = -1;
                    m_trunc = 1'b1;
                end
            end
        end
    endtask

    task automatic run_until_wr(input string tag, input int target, input int budget);
        int n = 0;
        while (phase_wr < target && n < budget) begin
            cycle();
            n++;
        end
        check(tag, 64'(n < budget), 64'd1);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (!all_empty() && n < budget) begin
            cycle();
            n++;
        end
        check(tag, 64'(n < budget), 64'd1);
        repeat (4) cycle();
    endtask

    initial begin
        rst         = 1'b1;
        fifo_f_full = 1'b0;
        req_valid   = '0;
        req_data    = '0;
        req_last    = '0;
        @(posedge clk);

        // Reset held with every requester valid
        for (int r = 0; r < N; r++) begin
            load_burst(r, 1);
            load_burst(r, 1);
        end
        rst_drv = 1'b1;
        repeat (2) cycle();

        // Round-robin of single-word bursts
        rst_drv  = 1'b0;
        phase_wr = 0;
        wr_gid.delete();
        repeat (10) cycle();
        check("rr_writes", 64'(phase_wr), 64'd5);
        for (int k = 0; k < 5; k++) begin
            check("rr_order", 64'(k < wr_gid.size() ? wr_gid[k] : -1), 64'(k % N));
        end
        drain("rr_drain", 200);

        // Burst cap: 20 words, last only on the final word
        phase_wr   = 0;
        trunc_seen = 0;
        load_burst(2, 20);
        drain("cap_drain", 200);
        check("cap_writes", 64'(phase_wr), 64'd20);
        check("cap_trunc_cnt", 64'(trunc_seen), 64'd1);

        // FIFO full for 3 cycles when word 5 is next
        phase_wr = 0;
        load_burst(0, 8);
        run_until_wr("stall_reach", 5, 100);
        full_drv = 1'b1;
        repeat (3) cycle();
        check("stall_no_wr", 64'(phase_wr), 64'd5);
        full_drv = 1'b0;
        drain("stall_drain", 100);
        check("stall_writes", 64'(phase_wr), 64'd8);

        // Owner drops valid for 4 cycles while another requester waits
        phase_wr = 0;
        load_burst(3, 8);
        run_until_wr("gap_reach", 3, 100);
        load_burst(1, 2);
        vmask[3] = 1'b0;
        repeat (4) cycle();
        check("gap_no_wr", 64'(phase_wr), 64'd3);
        check("gap_hold", 64'(grant_id), 64'd3);
        vmask = '1;
        drain("gap_drain", 100);

        // Reset in the middle of an 8-word burst
        phase_wr = 0;
        load_burst(2, 8);
        run_until_wr("mrst_reach", 3, 100);
        load_burst(0, 1);
        rst_drv = 1'b1;
        cycle();
        rst_drv = 1'b0;
        check("mrst_left", 64'(q[2].size()), 64'd5);
        check("mrst_written", 64'(phase_wr), 64'd3);
        wr_gid.delete();
        drain("mrst_drain", 200);
        check("mrst_first_gid", 64'(wr_gid.size() > 0 ? wr_gid[0] : -1), 64'd0);

        // Randomized traffic with stalls, gaps and occasional resets
        gap_pct  = 20;
        full_pct = 20;
        for (int c = 0; c < 1500; c++) begin
            for (int r = 0; r < N; r++) begin
                if (q[r].size() == 0 && $urandom_range(9) == 0) load_burst(r, $urandom_range(20, 1));
            end
            rst_drv = ($urandom_range(199) == 0);
            cycle();
        end
        rst_drv  = 1'b0;
        gap_pct  = 0;
        full_pct = 0;
        drain("rand_drain", 2000);
        for (int r = 0; r < N; r++) begin
            check("rand_empty", 64'(q[r].size()), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
